ram_bank_pipe: RTL and testbench
================================

RAM_BANK_PIPE -- requirements
Module: ram_bank_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_BIT, 3, address width.
- DATA_BIT, 16, data width; a multiple of 8.
- MEM_HEIGHT, 8, number of entries; at most 2**ADDR_BIT.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (BE = DATA_BIT/8).
- clk, in, 1, the single clock; all logic is rising-edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- en, in, 1, bank enable; gates new requests only.
- clr, in, 1, synchronous clear of the written-flag bitmap.
- we, in, 1, write request.
- be, in, BE, byte enables; bit i covers d_w[8i+7:8i].
- addr_w, in, ADDR_BIT, write address.
- d_w, in, DATA_BIT, write data.
- re, in, 1, read request.
- addr_r, in, ADDR_BIT, read address.
- d_r, out, DATA_BIT, read data.
- d_r_valid, out, 1, d_r holds the result of a read request.
- d_r_init, out, 1, the entry read had been written since the last reset or clear.
- rd_err, out, 1, the read address was out of range; aligned with d_r_valid.
- wr_err, out, 1, one-cycle pulse in the cycle after an out-of-range write.

Function
REQ-003 A write SHALL occur when en=1 and we=1 and addr_w<MEM_HEIGHT: each byte with be[i]=1 is stored; bytes with be[i]=0 are unchanged.
REQ-004 The write SHALL set the written flag of entry addr_w when be is not all zeros.
REQ-005 A write with addr_w>=MEM_HEIGHT SHALL leave the memory and the flags unchanged, and wr_err SHALL be 1 in the next cycle only.
REQ-006 A read SHALL be issued when en=1 and re=1.
REQ-007 A read's result SHALL appear exactly RD_LAT cycles after issue, with d_r_valid=1 for one cycle per issued read.
REQ-008 Back-to-back reads SHALL be accepted every cycle; throughput is 1 read per cycle.
REQ-009 Collision: on a same-cycle read and write to the same in-range address, the read SHALL return the merged word (new bytes where be=1, old bytes elsewhere), and d_r_init SHALL be 1 if be is not all zeros (write-first).
REQ-010 A read of an entry whose flag is 0 (and with no colliding write) SHALL return d_r=0 and d_r_init=0.
REQ-011 A read with addr_r>=MEM_HEIGHT SHALL return d_r=0, d_r_init=0 and rd_err=1.
REQ-012 When d_r_valid=0, d_r SHALL hold its last value, and d_r_init and rd_err SHALL be 0.
REQ-013 en=0 SHALL block new reads and writes; when RD_LAT=2, a read already issued SHALL still complete on schedule.
REQ-014 clr=1 SHALL zero all written flags at the clock edge; the memory array is not cleared.
REQ-015 clr and a write in the same cycle: the written entry's flag SHALL end at 1; all other flags SHALL end at 0.
REQ-016 clr and a read in the same cycle: the read SHALL see the pre-clear flags, plus any collision per REQ-009.
REQ-017 clr SHALL act regardless of en.
REQ-018 Resource: the memory array SHALL be a plain register array with no reset, so that it can be inferred as RAM; the flags are a MEM_HEIGHT-bit register.

Reset
REQ-019 While rst_n=0, the following SHALL be 0: d_r, d_r_valid, d_r_init, rd_err, wr_err, all written flags and all read-pipeline stage registers.
REQ-020 Reset asserted mid-operation SHALL cancel every in-flight read; no d_r_valid SHALL appear for reads issued before reset.
REQ-021 The first request SHALL be accepted on the first rising edge after rst_n deasserts.
REQ-022 Memory contents after reset are undefined, but SHALL be unobservable through d_r until written (REQ-010).

Verification
REQ-023 (RD_LAT=1) Reset, then read addr 3 -> after 1 cycle: d_r=0x0000, d_r_valid=1, d_r_init=0, rd_err=0.
REQ-024 Write addr 2, d_w=0xABCD, be=11; then write addr 2, d_w=0x1234, be=01; then read addr 2 -> d_r=0xAB34, d_r_init=1.
REQ-025 In the same cycle, write addr 5, 0x5555, be=10 over stored 0x00FF, and read addr 5 -> d_r=0x55FF next cycle.
REQ-026 Write addr 9 (ADDR_BIT=4, MEM_HEIGHT=8) -> wr_err pulses once and memory is unchanged; read addr 9 -> d_r=0, rd_err=1.
REQ-027 Write addr 1, then clr together with a write to addr 4, then read addr 1 and addr 4 -> d_r_init=0 for addr 1 and 1 for addr 4.
REQ-028 (RD_LAT=2) Issue reads on 3 consecutive cycles, then assert rst_n=0 after the second read -> no d_r_valid pulse after reset.

Source files
------------

// File: rtl/ram_bank_pipe_if.sv
// ram_bank_pipe_if: request/response bundle of one RAM bank (master = requester, slave = bank)
interface ram_bank_pipe_if #(
  parameter int ADDR_BIT = 3,
  parameter int DATA_BIT = 16
);
  localparam int BE = DATA_BIT / 8;
  logic                en;
  logic                clr;
  logic                we;
  logic [BE-1:0]       be;
  logic [ADDR_BIT-1:0] addr_w;
  logic [DATA_BIT-1:0] d_w;
  logic                re;
  logic [ADDR_BIT-1:0] addr_r;
  logic [DATA_BIT-1:0] d_r;
  logic                d_r_valid;
  logic                d_r_init;
  logic                rd_err;
  logic                wr_err;
  modport master (
    output en, clr, we, be, addr_w, d_w, re, addr_r,
    input  d_r, d_r_valid, d_r_init, rd_err, wr_err
  );
  modport slave (
    input  en, clr, we, be, addr_w, d_w, re, addr_r,
    output d_r, d_r_valid, d_r_init, rd_err, wr_err
  );
endinterface

// File: rtl/ram_bank_pipe.sv
// ram_bank_pipe: byte-enabled RAM bank with written-flag tracking, write-first collision and 1/2-cycle read pipe
module ram_bank_pipe #(
  parameter int ADDR_BIT   = 3,
  parameter int DATA_BIT   = 16,
  parameter int MEM_HEIGHT = 8,
  parameter int RD_LAT     = 1
) (
  input logic clk,
  input logic rst_n,
  ram_bank_pipe_if.slave bus
);
  localparam int BE = DATA_BIT / 8;
  localparam logic [ADDR_BIT:0] HEIGHT = (ADDR_BIT + 1)'(MEM_HEIGHT);
  logic [DATA_BIT-1:0]   mem [MEM_HEIGHT];
  logic [MEM_HEIGHT-1:0] flags_q, flags_d, wmask;
  logic                  w_in, r_in, wr_ok, rd_ok, hit, rd_init;
  logic [DATA_BIT-1:0]   old_w, rd_d;
  logic                  v1_q, init1_q, err1_q, wr_err_q;
  logic [DATA_BIT-1:0]   d1_q;
  assign w_in  = {1'b0, bus.addr_w} < HEIGHT;
  assign r_in  = {1'b0, bus.addr_r} < HEIGHT;
  assign wr_ok = bus.en && bus.we && w_in;
  assign rd_ok = bus.en && bus.re;
  assign hit   = wr_ok && r_in && bus.addr_w == bus.addr_r && |bus.be;
  // Unwritten entries read as zero so uninitialised RAM never leaks out
  always_comb begin
    old_w = (r_in && flags_q[bus.addr_r]) ? mem[bus.addr_r] : '0;
    rd_d  = old_w;
    for (int i = 0; i < BE; i++)
      if (hit && bus.be[i]) rd_d[8*i +: 8] = bus.d_w[8*i +: 8];
    rd_init = r_in && (flags_q[bus.addr_r] || hit);
    wmask   = (wr_ok && |bus.be) ? MEM_HEIGHT'(1) << bus.addr_w : '0;
    flags_d = (bus.clr ? '0 : flags_q) | wmask;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < BE; i++)
      if (wr_ok && bus.be[i]) mem[bus.addr_w][8*i +: 8] <= bus.d_w[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flags_q  <= '0;
      wr_err_q <= 1'b0;
      v1_q     <= 1'b0;
      init1_q  <= 1'b0;
      err1_q   <= 1'b0;
      d1_q     <= '0;
    end else begin
      flags_q  <= flags_d;
      wr_err_q <= bus.en && bus.we && !w_in;
      v1_q     <= rd_ok;
      init1_q  <= rd_ok && rd_init;
      err1_q   <= rd_ok && !r_in;
      if (rd_ok) d1_q <= rd_d;
    end
  assign bus.wr_err = wr_err_q;
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                v2_q, init2_q, err2_q;
      logic [DATA_BIT-1:0] d2_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v2_q    <= 1'b0;
          init2_q <= 1'b0;
          err2_q  <= 1'b0;
          d2_q    <= '0;
        end else begin
          v2_q    <= v1_q;
          init2_q <= init1_q;
          err2_q  <= err1_q;
          if (v1_q) d2_q <= d1_q;
        end
      assign bus.d_r       = d2_q;
      assign bus.d_r_valid = v2_q;
      assign bus.d_r_init  = init2_q;
      assign bus.rd_err    = err2_q;
    end else begin : g_lat1
      assign bus.d_r       = d1_q;
      assign bus.d_r_valid = v1_q;
      assign bus.d_r_init  = init1_q;
      assign bus.rd_err    = err1_q;
    end
  endgenerate
endmodule

// File: tb/tb_ram_bank_pipe.sv
// tb_ram_bank_pipe: drives RD_LAT=1 and RD_LAT=2 banks with identical stimulus against a scoreboard model
module tb_ram_bank_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en, clr, we, re;
  logic [1:0] be;
  logic [3:0] addr_w, addr_r;
  logic [15:0] d_w;
  typedef struct {int due; logic [15:0] d; logic init; logic err;} exp_t;
  exp_t q1[$], q2[$];
  logic [15:0] m_mem [8];
  logic [7:0] m_flag = '0;
  logic [15:0] last1 = '0, last2 = '0;
  logic [18:0] got, exp_v;
  int cyc = 0, werr_due = -1, n_cmp = 0, n_bad = 0;

  ram_bank_pipe_if #(.ADDR_BIT(4), .DATA_BIT(16)) b1();
  ram_bank_pipe_if #(.ADDR_BIT(4), .DATA_BIT(16)) b2();
  assign {b1.en, b1.clr, b1.we, b1.be, b1.addr_w, b1.d_w, b1.re, b1.addr_r} = {en, clr, we, be, addr_w, d_w, re, addr_r};
  assign {b2.en, b2.clr, b2.we, b2.be, b2.addr_w, b2.d_w, b2.re, b2.addr_r} = {en, clr, we, be, addr_w, d_w, re, addr_r};
  ram_bank_pipe #(.ADDR_BIT(4), .DATA_BIT(16), .MEM_HEIGHT(8), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ram_bank_pipe #(.ADDR_BIT(4), .DATA_BIT(16), .MEM_HEIGHT(8), .RD_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;

  // Scoreboard: pop the read due this cycle, otherwise expect an idle, data-holding output
  always @(posedge clk) begin
    cyc++;
    #1;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_v = {1'b1, q1[0].init, q1[0].err, q1[0].d};
      last1 = q1[0].d;
      void'(q1.pop_front());
    end else exp_v = {3'b000, last1};
    got = {b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.d_r};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL lat1_out cyc=%0d got=%h exp=%h", cyc, got, exp_v); end
    if (q2.size() > 0 && q2[0].due == cyc) begin
      exp_v = {1'b1, q2[0].init, q2[0].err, q2[0].d};
      last2 = q2[0].d;
      void'(q2.pop_front());
    end else exp_v = {3'b000, last2};
    got = {b2.d_r_valid, b2.d_r_init, b2.rd_err, b2.d_r};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("FAIL lat2_out cyc=%0d got=%h exp=%h", cyc, got, exp_v); end
    n_cmp++;
    if ({b1.wr_err, b2.wr_err} !== {2{werr_due == cyc}}) begin
      n_bad++; $display("FAIL wr_err cyc=%0d got=%b exp=%b", cyc, {b1.wr_err, b2.wr_err}, werr_due == cyc);
    end
  end

  task automatic step();
    logic in_r, wok, hit;
    logic [15:0] v;
    exp_t e;
    if (!rst_n) begin
      q1.delete(); q2.delete();
      m_flag = '0; werr_due = -1; last1 = '0; last2 = '0;
    end else begin
      in_r = addr_r < 4'd8;
      wok  = en && we && addr_w < 4'd8;
      hit  = wok && in_r && addr_w == addr_r && be != 2'b00;
      if (en && re) begin
        v = (in_r && m_flag[addr_r[2:0]]) ? m_mem[addr_r[2:0]] : 16'h0000;
        if (hit && be[0]) v[7:0] = d_w[7:0];
        if (hit && be[1]) v[15:8] = d_w[15:8];
        e.d = v; e.init = in_r && (m_flag[addr_r[2:0]] || hit); e.err = !in_r;
        e.due = cyc + 1; q1.push_back(e);
        e.due = cyc + 2; q2.push_back(e);
      end
      if (en && we && addr_w >= 4'd8) werr_due = cyc + 1;
      if (clr) m_flag = '0;
      if (wok) begin
        if (be[0]) m_mem[addr_w[2:0]][7:0] = d_w[7:0];
        if (be[1]) m_mem[addr_w[2:0]][15:8] = d_w[15:8];
        if (be != 2'b00) m_flag[addr_w[2:0]] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; be = 2'b00;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; addr_w = a; d_w = d; be = b;
  endtask

  task automatic rd(input logic [3:0] a);
    re = 1'b1; addr_r = a;
  endtask

  task automatic test_reset();
    idle(); addr_w = '0; addr_r = '0; d_w = '0;
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.wr_err, b1.d_r, b2.d_r_valid, b2.d_r} !== 37'h0) begin
      n_bad++; $display("FAIL reset_state got=%h %h exp=0", {b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.wr_err, b1.d_r}, {b2.d_r_valid, b2.d_r});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unwritten();
    idle(); rd(4'd3); step();
    n_cmp++;
    if ({b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.d_r} !== {3'b100, 16'h0000}) begin
      n_bad++; $display("FAIL unwritten got=%h exp=%h", {b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.d_r}, {3'b100, 16'h0000});
    end
  endtask

  task automatic test_byte_enable();
    idle(); wr(4'd2, 16'hABCD, 2'b11); step();
    idle(); wr(4'd2, 16'h1234, 2'b01); step();
    idle(); rd(4'd2); step();
    n_cmp++;
    if ({b1.d_r_init, b1.d_r} !== {1'b1, 16'hAB34}) begin
      n_bad++; $display("FAIL byte_enable got=%h exp=%h", {b1.d_r_init, b1.d_r}, {1'b1, 16'hAB34});
    end
  endtask

  task automatic test_collision();
    idle(); wr(4'd5, 16'h00FF, 2'b11); step();
    idle(); wr(4'd5, 16'h5555, 2'b10); rd(4'd5); step();
    n_cmp++;
    if ({b1.d_r_valid, b1.d_r_init, b1.d_r} !== {2'b11, 16'h55FF}) begin
      n_bad++; $display("FAIL collision got=%h exp=%h", {b1.d_r_valid, b1.d_r_init, b1.d_r}, {2'b11, 16'h55FF});
    end
    idle(); step();
    n_cmp++;
    if (b2.d_r !== 16'h55FF) begin n_bad++; $display("FAIL collision_lat2 got=%h exp=55ff", b2.d_r); end
  endtask

  task automatic test_out_of_range();
    idle(); wr(4'd1, 16'h1111, 2'b11); step();
    idle(); wr(4'd9, 16'hFFFF, 2'b11); step();
    n_cmp++;
    if (b1.wr_err !== 1'b1) begin n_bad++; $display("FAIL wr_err_pulse got=%b exp=1", b1.wr_err); end
    idle(); rd(4'd9); step();
    n_cmp++;
    if ({b1.wr_err, b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.d_r} !== {4'b0101, 16'h0000}) begin
      n_bad++; $display("FAIL rd_oor got=%h exp=%h", {b1.wr_err, b1.d_r_valid, b1.d_r_init, b1.rd_err, b1.d_r}, {4'b0101, 16'h0000});
    end
    idle(); rd(4'd1); step();
    n_cmp++;
    if (b1.d_r !== 16'h1111) begin n_bad++; $display("FAIL oor_no_write got=%h exp=1111", b1.d_r); end
  endtask

  task automatic test_clear();
    idle(); wr(4'd1, 16'hA1A1, 2'b11); step();
    idle(); clr = 1'b1; wr(4'd4, 16'h4444, 2'b11); step();
    idle(); rd(4'd1); step();
    n_cmp++;
    if ({b1.d_r_init, b1.d_r} !== {1'b0, 16'h0000}) begin
      n_bad++; $display("FAIL clr_other got=%h exp=%h", {b1.d_r_init, b1.d_r}, {1'b0, 16'h0000});
    end
    idle(); rd(4'd4); step();
    n_cmp++;
    if ({b1.d_r_init, b1.d_r} !== {1'b1, 16'h4444}) begin
      n_bad++; $display("FAIL clr_written got=%h exp=%h", {b1.d_r_init, b1.d_r}, {1'b1, 16'h4444});
    end
    idle(); clr = 1'b1; rd(4'd4); step();
    n_cmp++;
    if (b1.d_r_init !== 1'b1) begin n_bad++; $display("FAIL clr_read_preclear got=%b exp=1", b1.d_r_init); end
    idle(); wr(4'd6, 16'h6666, 2'b11); step();
    idle(); en = 1'b0; clr = 1'b1; step();
    idle(); rd(4'd6); step();
    n_cmp++;
    if (b1.d_r_init !== 1'b0) begin n_bad++; $display("FAIL clr_no_en got=%b exp=0", b1.d_r_init); end
  endtask

  task automatic test_enable();
    idle(); wr(4'd7, 16'h7777, 2'b11); step();
    idle(); en = 1'b0; wr(4'd7, 16'h0BAD, 2'b11); rd(4'd7); step();
    n_cmp++;
    if (b1.d_r_valid !== 1'b0) begin n_bad++; $display("FAIL en_blocks_read got=%b exp=0", b1.d_r_valid); end
    idle(); rd(4'd7); step();
    n_cmp++;
    if (b1.d_r !== 16'h7777) begin n_bad++; $display("FAIL en_blocks_write got=%h exp=7777", b1.d_r); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [6] = '{4'd2, 4'd5, 4'd4, 4'd1, 4'd12, 4'd7};
    foreach (seq[i]) begin idle(); rd(seq[i]); step(); end
    idle(); step(); step();
  endtask

  task automatic test_random();
    for (int a = 0; a < 8; a++) begin idle(); wr(4'(a), 16'($urandom), 2'b11); step(); end
    for (int n = 0; n < 300; n++) begin
      idle();
      en = $urandom_range(0, 7) != 0;
      clr = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 1) == 1) wr(4'($urandom_range(0, 10)), 16'($urandom), 2'($urandom));
      if ($urandom_range(0, 2) != 0) rd(4'($urandom_range(0, 10)));
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_reset_inflight();
    idle(); rd(4'd2); step();
    idle(); rd(4'd5); step();
    idle(); rd(4'd4); rst_n = 1'b0; step();
    n_cmp++;
    if ({b1.d_r_valid, b2.d_r_valid, b2.d_r} !== 18'h0) begin
      n_bad++; $display("FAIL reset_cancel got=%h exp=0", {b1.d_r_valid, b2.d_r_valid, b2.d_r});
    end
    idle(); step();
    rst_n = 1'b1;
    idle(); rd(4'd3); step();
    n_cmp++;
    if ({b1.d_r_valid, b2.d_r_valid} !== 2'b10) begin
      n_bad++; $display("FAIL first_after_reset got=%b exp=10", {b1.d_r_valid, b2.d_r_valid});
    end
    idle(); step(); step();
  endtask

  initial begin
    test_reset();
    test_unwritten();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_clear();
    test_enable();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
